// File: rtl/mux_memoria_nch_arb.sv
// N-channel FIFO mux: per-channel DEPTH-entry FIFOs drained by an arbiter into a registered
// valid/ready output stage. Define MUX_MEM_RR_EN for round-robin arbitration, else fixed priority.
module mux_memoria_nch_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   data_in,
  input  logic [NCH-1:0]         valid_in,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   out_valid,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic [NCH-1:0]         fifo_full,
  output logic [NCH-1:0]         fifo_empty,
  output logic [NCH-1:0]         err_ovf
);
  localparam int CHW = $clog2(NCH);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [WIDTH-1:0] mem       [NCH][DEPTH];
  logic [PW-1:0]    wr_ptr    [NCH];
  logic [PW-1:0]    rd_ptr    [NCH];
  logic [CW-1:0]    count     [NCH];
  logic [CW-1:0]    count_nxt [NCH];
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   non_empty;
  logic             load;
  logic             any_ne;
  logic [CHW-1:0]   grant;
`ifdef MUX_MEM_RR_EN
  logic [CHW-1:0]   last_grant;
  logic [CHW-1:0]   idx;
  logic             found;
`endif

  // A full FIFO refuses the write even if it is popped on the same edge.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      non_empty[i] = (count[i] != '0);
      push[i]      = valid_in[i] && (count[i] != CW'(DEPTH));
    end
  end

  assign any_ne = |non_empty;
  assign load   = !out_valid || out_ready;

`ifdef MUX_MEM_RR_EN
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = (last_grant == CHW'(NCH - 1)) ? '0 : last_grant + 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (!found && non_empty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
      idx = (idx == CHW'(NCH - 1)) ? '0 : idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (non_empty[i]) grant = CHW'(i);
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pop[i]       = load && any_ne && (grant == CHW'(i));
      count_nxt[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      data_out   <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      fifo_full  <= '0;
      fifo_empty <= '1;
      err_ovf    <= '0;
`ifdef MUX_MEM_RR_EN
      last_grant <= CHW'(NCH - 1);
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i]      <= count_nxt[i];
        fifo_full[i]  <= (count_nxt[i] == CW'(DEPTH));
        fifo_empty[i] <= (count_nxt[i] == '0);
        err_ovf[i]    <= valid_in[i] && !push[i];
      end
      // When nothing is queued the stage empties but data_out keeps its last word.
      if (load) begin
        if (any_ne) begin
          data_out  <= mem[grant][rd_ptr[grant]];
          out_ch    <= grant;
          out_valid <= 1'b1;
`ifdef MUX_MEM_RR_EN
          last_grant <= grant;
`endif
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!reset && push[i]) mem[i][wr_ptr[i]] <= data_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_mux_memoria_nch_arb.sv
// Self-checking bench for mux_memoria_nch_arb (WIDTH=8, NCH=2, DEPTH=4): queue-based model
// checked every cycle plus directed scenarios with literal expectations.
module tb_mux_memoria_nch_arb;
  localparam int WIDTH = 8;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic [1:0]  valid_in = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ch;
  logic [1:0]  fifo_full;
  logic [1:0]  fifo_empty;
  logic [1:0]  err_ovf;

  int n_checks = 0;
  int n_fail = 0;
  logic check_en = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_ch = 1'b0;
  logic [1:0] m_err = '0;
  int         m_last = NCH - 1;

  logic [7:0] cap_data[$];
  logic       cap_ch[$];

  mux_memoria_nch_arb #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .out_ready(out_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ch(out_ch), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs at a negedge, log words the downstream will accept, advance a cycle.
  task automatic applyStimulus(input logic [1:0] v, input logic [7:0] d0,
                               input logic [7:0] d1, input logic rdy);
    valid_in  = v;
    data_in   = {d1, d0};
    out_ready = rdy;
    if (out_valid && rdy) begin
      cap_data.push_back(data_out);
      cap_ch.push_back(out_ch);
    end
    @(negedge clk);
  endtask

  // Reference model: per-channel queues plus one output slot, updated from pre-edge occupancy.
  initial forever begin
    int  pre0;
    int  pre1;
    int  g;
    int  c;
    @(posedge clk);
    pre0 = q0.size();
    pre1 = q1.size();
    if (reset) begin
      q0.delete();
      q1.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ch    = 1'b0;
      m_err   = '0;
      m_last  = NCH - 1;
    end else begin
      g = -1;
`ifdef MUX_MEM_RR_EN
      for (int k = 0; k < NCH; k++) begin
        c = (m_last + 1 + k) % NCH;
        if (g < 0 && ((c == 0 && pre0 > 0) || (c == 1 && pre1 > 0))) g = c;
      end
`else
      c = 0;
      if (pre0 > 0) g = 0;
      else if (pre1 > 0) g = 1;
`endif
      if (!m_valid || out_ready) begin
        if (g == 0) begin
          m_data = q0.pop_front(); m_ch = 1'b0; m_valid = 1'b1; m_last = 0;
        end else if (g == 1) begin
          m_data = q1.pop_front(); m_ch = 1'b1; m_valid = 1'b1; m_last = 1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_err = '0;
      if (valid_in[0]) begin
        if (pre0 < DEPTH) q0.push_back(data_in[7:0]); else m_err[0] = 1'b1;
      end
      if (valid_in[1]) begin
        if (pre1 < DEPTH) q1.push_back(data_in[15:8]); else m_err[1] = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("mdl_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("mdl_data",  32'(data_out),  32'(m_data));
      checkOutput("mdl_ch",    32'(out_ch),    32'(m_ch));
      checkOutput("mdl_err",   32'(err_ovf),   32'(m_err));
      checkOutput("mdl_full",  32'(fifo_full),
                  32'({q1.size() == DEPTH, q0.size() == DEPTH}));
      checkOutput("mdl_empty", 32'(fifo_empty),
                  32'({q1.size() == 0, q0.size() == 0}));
    end
  end

  initial begin
    logic [7:0] exp3_data [8];
    logic       exp3_ch   [8];
    logic [7:0] a;
    logic       hold;
    logic [7:0] held;
    logic       rdy;
    logic [1:0] v;

`ifdef MUX_MEM_RR_EN
    exp3_data = '{8'h00, 8'h03, 8'h01, 8'h04, 8'h02, 8'h05, 8'h03, 8'h06};
    exp3_ch   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp3_data = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h04, 8'h05, 8'h06};
    exp3_ch   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    @(negedge clk);
    check_en = 1'b1;

    // Reset held with writes requested: everything stays idle.
    applyStimulus(2'b11, 8'hAA, 8'hBB, 1'b1);
    applyStimulus(2'b11, 8'hAA, 8'hBB, 1'b1);
    checkOutput("t1_valid", 32'(out_valid), 32'd0);
    checkOutput("t1_data",  32'(data_out),  32'd0);
    checkOutput("t1_empty", 32'(fifo_empty), 32'd3);
    checkOutput("t1_err",   32'(err_ovf),   32'd0);
    reset = 1'b0;

    $display("[TB] single write latency");
    applyStimulus(2'b01, 8'h05, 8'h00, 1'b1);
    checkOutput("t2_nobypass", 32'(out_valid), 32'd0);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
    checkOutput("t2_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_data",  32'(data_out),  32'h05);
    checkOutput("t2_ch",    32'(out_ch),    32'd0);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
    checkOutput("t2_drain", 32'(out_valid), 32'd0);

    reset = 1'b1;
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
    reset = 1'b0;

    $display("[TB] two-channel arbitration");
    cap_data.delete();
    cap_ch.delete();
    for (int k = 0; k < 4; k++) applyStimulus(2'b11, 8'(k), 8'(k + 3), 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
    checkOutput("t3_count", 32'(cap_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      a = (i < cap_data.size()) ? cap_data[i] : 8'hxx;
      checkOutput($sformatf("t3_data%0d", i), 32'(a), 32'(exp3_data[i]));
      a = (i < cap_ch.size()) ? 8'(cap_ch[i]) : 8'hxx;
      checkOutput($sformatf("t3_ch%0d", i), 32'(a), 32'(exp3_ch[i]));
    end

    $display("[TB] backpressure and overflow");
    cap_data.delete();
    cap_ch.delete();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b01, 8'(8'h10 + k), 8'h00, 1'b0);
      if (k == 4) begin
        checkOutput("t4_full", 32'(fifo_full[0]), 32'd1);
        checkOutput("t4_noerr", 32'(err_ovf[0]), 32'd0);
      end
    end
    checkOutput("t4_err",   32'(err_ovf[0]), 32'd1);
    checkOutput("t4_held",  32'(data_out),   32'h10);
    checkOutput("t4_hvld",  32'(out_valid),  32'd1);
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);
    checkOutput("t4_pulse", 32'(err_ovf[0]), 32'd0);
    for (int k = 0; k < 8; k++) applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
    checkOutput("t4_count", 32'(cap_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      a = (i < cap_data.size()) ? cap_data[i] : 8'hxx;
      checkOutput($sformatf("t4_data%0d", i), 32'(a), 32'(8'h10 + i));
    end

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 3; k++) applyStimulus(2'b10, 8'h00, 8'(8'h30 + k), 1'b0);
    reset = 1'b1;
    applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
    checkOutput("t5_valid", 32'(out_valid),  32'd0);
    checkOutput("t5_empty", 32'(fifo_empty), 32'd3);
    checkOutput("t5_data",  32'(data_out),   32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
      checkOutput($sformatf("t5_idle%0d", k), 32'(out_valid), 32'd0);
    end

    $display("[TB] toggling ready with pointer wrap");
    cap_data.delete();
    cap_ch.delete();
    hold = 1'b0;
    held = '0;
    for (int k = 0; k < 30; k++) begin
      if (hold) checkOutput($sformatf("t6_stable%0d", k), 32'(data_out), 32'(held));
      checkOutput($sformatf("t6_err%0d", k), 32'(err_ovf), 32'd0);
      rdy  = (k % 2 == 0);
      v    = (k < 20 && k % 2 == 0) ? 2'b10 : 2'b00;
      hold = out_valid && !rdy;
      held = data_out;
      applyStimulus(v, 8'h00, 8'(8'h20 + k / 2), rdy);
    end
    checkOutput("t6_count", 32'(cap_data.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      a = (i < cap_data.size()) ? cap_data[i] : 8'hxx;
      checkOutput($sformatf("t6_data%0d", i), 32'(a), 32'(8'h20 + i));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
